// File: rtl/dtmf_pkg.sv
// Shared constants for the DTMF digit collector: digit codes, FSM state
// encoding, register offsets and the STATUS register layout.
package dtmf_pkg;

    // Decoder codes with special meaning; every other code is stored as-is.
    localparam logic [3:0] CODE_STAR = 4'd11;
    localparam logic [3:0] CODE_HASH = 4'd12;

    // Collector FSM encoding.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_QUALIFY  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_COMPLETE = 2'd3;

    // Register offsets relative to the window base.
    localparam logic [7:0] OFF_STATUS  = 8'd0;
    localparam logic [7:0] OFF_CONTROL = 8'd1;
    localparam logic [7:0] OFF_DIGIT0  = 8'd2;

    // CONTROL register bit positions.
    localparam int CTL_ACK_BIT = 0;
    localparam int CTL_EN_BIT  = 1;

    // STATUS register layout, MSB first.
    typedef struct packed {
        logic       cmd_valid;
        logic       tmo;
        logic       overflow;
        logic       enable;
        logic [3:0] count;
    } status_t;

    function automatic logic [7:0] pack_status(input status_t s);
        return s;
    endfunction

endpackage

// File: rtl/dtmf_digit_collector_if.sv
// Register-bus bundle of the collector, including the read-data daisy chain.
interface dtmf_digit_collector_if;
    logic       rdena;
    logic       wrena;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data_in;
    logic [7:0] rd_data;

    modport master (
        output rdena, wrena, reg_addr, wr_data, rd_data_in,
        input  rd_data
    );

    modport slave (
        input  rdena, wrena, reg_addr, wr_data, rd_data_in,
        output rd_data
    );
endinterface

// File: rtl/dtmf_tone_qualifier.sv
// Detect edge finder plus on-time qualifier: samples the digit code on an armed
// rising edge and strobes once when the tone has stayed on long enough.
module dtmf_tone_qualifier #(
    parameter int MIN_ON_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       detect,
    input  logic [3:0] digit_in,
    input  logic       arm,
    input  logic       cancel,
    output logic       rise,
    output logic       digit_strobe,
    output logic [3:0] digit_code
);

    localparam int               CNT_W   = $clog2(MIN_ON_CYCLES + 1);
    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);

    logic             prev_r;
    logic             counting_r;
    logic [CNT_W-1:0] on_cnt_r;
    logic [3:0]       digit_r;
    logic             rise_s;
    logic             hit_s;

    assign rise_s       = detect & ~prev_r;
    assign hit_s        = counting_r & detect & (on_cnt_r == ON_LAST);
    assign rise         = rise_s;
    assign digit_strobe = hit_s;
    assign digit_code   = digit_r;

    // Edge history (reset high so a tone present at release never counts) and on-time counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_r     <= 1'b1;
            counting_r <= 1'b0;
            on_cnt_r   <= '0;
            digit_r    <= 4'd0;
        end else begin
            prev_r <= detect;
            if (cancel) begin
                counting_r <= 1'b0;
                on_cnt_r   <= '0;
            end else if (arm && rise_s) begin
                counting_r <= 1'b1;
                on_cnt_r   <= '0;
                digit_r    <= digit_in;
            end else if (counting_r) begin
                if (!detect || hit_s) begin
                    counting_r <= 1'b0;
                end else begin
                    on_cnt_r <= on_cnt_r + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dtmf_digit_collector.sv
// DTMF digit collector: qualifies tones into digits, buffers a command,
// terminates it on '#' or inter-digit timeout, and exposes it through a
// daisy-chained register window.
module dtmf_digit_collector
    import dtmf_pkg::*;
#(
    parameter int         MAX_DIGITS     = 8,
    parameter int         MIN_ON_CYCLES  = 1024,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0] BASE_ADDR      = 8'h40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   DTMF_Detect,
    input  logic [3:0]             DTMF_Digit,
    dtmf_digit_collector_if.slave  bus,
    output logic                   Cmd_valid,
    output logic [3:0]             Cmd_len
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       CNT_MAX  = 4'(MAX_DIGITS);
    localparam logic [7:0]       WIN_END  = OFF_DIGIT0 + 8'(MAX_DIGITS);

    logic [1:0]                  state_r, state_n;
    logic [3:0]                  count_r, count_n;
    logic [MAX_DIGITS-1:0][3:0]  buf_r, buf_n;
    logic                        tmo_r, tmo_n;
    logic                        ovf_r, ovf_n;
    logic                        enable_r, enable_n;
    logic                        term_r, term_n;
    logic [TMR_W-1:0]            timer_r, timer_n;
    logic                        cmd_valid_r;
    logic [7:0]                  rd_data_r;

    logic [7:0] off_s;
    logic [7:0] dig_idx_s;
    logic       hit_s;
    logic       ctl_wr_s;
    logic       ack_s;
    logic       dis_s;
    logic       arm_s;
    logic       cancel_s;
    logic       rise_s;
    logic       strobe_s;
    logic [3:0] code_s;
    logic       timeout_s;
    logic [7:0] local_s;
    status_t    status_s;

    assign off_s     = bus.reg_addr - BASE_ADDR;
    assign dig_idx_s = off_s - OFF_DIGIT0;
    assign hit_s     = (off_s < WIN_END);
    assign ctl_wr_s  = bus.wrena & (off_s == OFF_CONTROL);
    assign ack_s     = ctl_wr_s & bus.wr_data[CTL_ACK_BIT];
    assign dis_s     = ctl_wr_s & ~bus.wr_data[CTL_EN_BIT];
    assign cancel_s  = ack_s | dis_s;
    assign timeout_s = (state_r == ST_IDLE) && (count_r != 4'd0) && (timer_r == TMR_LAST);
    // A new tone may start only from IDLE, while enabled, and never in a cycle that clears or times out.
    assign arm_s     = (state_r == ST_IDLE) & enable_r & ~cancel_s & ~timeout_s;

    dtmf_tone_qualifier #(
        .MIN_ON_CYCLES (MIN_ON_CYCLES)
    ) u_qual (
        .clk          (clk),
        .reset        (reset),
        .detect       (DTMF_Detect),
        .digit_in     (DTMF_Digit),
        .arm          (arm_s),
        .cancel       (cancel_s),
        .rise         (rise_s),
        .digit_strobe (strobe_s),
        .digit_code   (code_s)
    );

    // Next-state logic for the FSM, digit buffer, flags and inter-digit timer.
    always_comb begin
        state_n  = state_r;
        count_n  = count_r;
        buf_n    = buf_r;
        tmo_n    = tmo_r;
        ovf_n    = ovf_r;
        term_n   = term_r;
        timer_n  = timer_r;
        enable_n = enable_r;
        if (ctl_wr_s) begin
            enable_n = bus.wr_data[CTL_EN_BIT];
        end else begin
            enable_n = enable_r;
        end
        if (cancel_s) begin
            state_n = ST_IDLE;
            count_n = 4'd0;
            buf_n   = '0;
            tmo_n   = 1'b0;
            ovf_n   = 1'b0;
            term_n  = 1'b0;
            timer_n = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (timeout_s) begin
                        state_n = ST_COMPLETE;
                        tmo_n   = 1'b1;
                    end else if (arm_s && rise_s) begin
                        state_n = ST_QUALIFY;
                    end else if (count_r != 4'd0) begin
                        timer_n = timer_r + TMR_W'(1);
                    end else begin
                        timer_n = timer_r;
                    end
                end
                ST_QUALIFY: begin
                    if (strobe_s) begin
                        state_n = ST_HELD;
                        timer_n = '0;
                        if (code_s == CODE_STAR) begin
                            count_n = 4'd0;
                            buf_n   = '0;
                            ovf_n   = 1'b0;
                        end else if (code_s == CODE_HASH) begin
                            if (count_r != 4'd0) begin
                                term_n = 1'b1;
                                tmo_n  = 1'b0;
                            end else begin
                                term_n = term_r;
                            end
                        end else if (count_r == CNT_MAX) begin
                            ovf_n = 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_DIGITS; i++) begin
                                if (4'(i) == count_r) begin
                                    buf_n[i] = code_s;
                                end else begin
                                    buf_n[i] = buf_r[i];
                                end
                            end
                            count_n = count_r + 4'd1;
                        end
                    end else if (!DTMF_Detect) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_QUALIFY;
                    end
                end
                ST_HELD: begin
                    if (term_r) begin
                        state_n = ST_COMPLETE;
                        term_n  = 1'b0;
                    end else if (!DTMF_Detect) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_HELD;
                    end
                end
                ST_COMPLETE: begin
                    state_n = ST_COMPLETE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Local read value for whichever register of the window is addressed.
    always_comb begin
        status_s.cmd_valid = cmd_valid_r;
        status_s.tmo       = tmo_r;
        status_s.overflow  = ovf_r;
        status_s.enable    = enable_r;
        status_s.count     = count_r;
        local_s            = 8'd0;
        if (off_s == OFF_STATUS) begin
            local_s = pack_status(status_s);
        end else if (off_s == OFF_CONTROL) begin
            local_s = {6'd0, enable_r, 1'b0};
        end else begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                if ((8'(i) == dig_idx_s) && (4'(i) < count_r)) begin
                    local_s = {4'd0, buf_r[i]};
                end else begin
                    local_s = local_s;
                end
            end
        end
    end

    // State, buffer and register-port flops; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 4'd0;
            buf_r       <= '0;
            tmo_r       <= 1'b0;
            ovf_r       <= 1'b0;
            enable_r    <= 1'b1;
            term_r      <= 1'b0;
            timer_r     <= '0;
            cmd_valid_r <= 1'b0;
            rd_data_r   <= 8'h00;
        end else begin
            state_r     <= state_n;
            count_r     <= count_n;
            buf_r       <= buf_n;
            tmo_r       <= tmo_n;
            ovf_r       <= ovf_n;
            enable_r    <= enable_n;
            term_r      <= term_n;
            timer_r     <= timer_n;
            cmd_valid_r <= (state_n == ST_COMPLETE);
            rd_data_r   <= (bus.rdena && hit_s) ? local_s : bus.rd_data_in;
        end
    end

    assign bus.rd_data = rd_data_r;
    assign Cmd_valid   = cmd_valid_r;
    assign Cmd_len     = count_r;

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// Scoreboard bench for the DTMF digit collector: register reads push their
// expected result, a negedge monitor pops and compares when the data appears.
module tb_dtmf_digit_collector;

    localparam int         MAXD  = 8;
    localparam int         MINON = 1024;
    localparam int         TMO   = 3000;
    localparam logic [7:0] BASE  = 8'h40;
    localparam logic [7:0] A_ST  = 8'h40;
    localparam logic [7:0] A_CTL = 8'h41;
    localparam logic [7:0] A_D0  = 8'h42;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       det = 1'b0;
    logic [3:0] dig = 4'd0;
    logic       cmd_valid;
    logic [3:0] cmd_len;

    dtmf_digit_collector_if bus();

    dtmf_digit_collector #(
        .MAX_DIGITS     (MAXD),
        .MIN_ON_CYCLES  (MINON),
        .TIMEOUT_CYCLES (TMO),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .DTMF_Detect (det),
        .DTMF_Digit  (dig),
        .bus         (bus),
        .Cmd_valid   (cmd_valid),
        .Cmd_len     (cmd_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] rd;
        logic       valid;
        logic [3:0] len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_pend = 1'b0;

    always @(posedge clk) rd_pend <= bus.rdena;

    // Monitor: read data is presented one cycle after the strobe.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_pend) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read rd_data=%h with empty scoreboard", bus.rd_data);
            end else begin
                e = sb.pop_front();
                checks++;
                if (bus.rd_data !== e.rd) begin
                    errors++;
                    $display("FAIL %s rd_data got %h expected %h", e.name, bus.rd_data, e.rd);
                end
                checks++;
                if (cmd_valid !== e.valid) begin
                    errors++;
                    $display("FAIL %s Cmd_valid got %b expected %b", e.name, cmd_valid, e.valid);
                end
                checks++;
                if (cmd_len !== e.len) begin
                    errors++;
                    $display("FAIL %s Cmd_len got %0d expected %0d", e.name, cmd_len, e.len);
                end
            end
        end
    end

    // All tasks start and end on a negedge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp_rd,
                      input logic exp_v, input logic [3:0] exp_l, input string nm);
        exp_t e;
        e.name  = nm;
        e.rd    = exp_rd;
        e.valid = exp_v;
        e.len   = exp_l;
        sb.push_back(e);
        bus.rdena    = 1'b1;
        bus.reg_addr = addr;
        @(negedge clk);
        bus.rdena    = 1'b0;
        bus.reg_addr = 8'h00;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus.wrena    = 1'b1;
        bus.reg_addr = addr;
        bus.wr_data  = data;
        @(negedge clk);
        bus.wrena    = 1'b0;
        bus.reg_addr = 8'h00;
        bus.wr_data  = 8'h00;
    endtask

    task automatic tone(input logic [3:0] code, input int on_c, input int off_c);
        dig = code;
        det = 1'b1;
        cyc(on_c);
        det = 1'b0;
        cyc(off_c);
    endtask

    initial begin
        bus.rdena      = 1'b0;
        bus.wrena      = 1'b0;
        bus.reg_addr   = 8'h00;
        bus.wr_data    = 8'h00;
        bus.rd_data_in = 8'h00;
        @(negedge clk);
        cyc(3);
        rd(A_ST, 8'h00, 1'b0, 4'd0, "reset_rd_data");
        reset = 1'b1;
        cyc(2);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "reset_status");
        rd(A_CTL, 8'h02, 1'b0, 4'd0, "reset_control");

        // 1,2,3,# -> complete command of three digits
        tone(4'd1, 1100, 20);
        tone(4'd2, 1100, 20);
        tone(4'd3, 1100, 20);
        tone(4'd12, 1100, 20);
        rd(A_ST, 8'h93, 1'b1, 4'd3, "hash_status");
        rd(A_D0, 8'h01, 1'b1, 4'd3, "hash_digit0");
        rd(A_D0 + 8'd1, 8'h02, 1'b1, 4'd3, "hash_digit1");
        rd(A_D0 + 8'd2, 8'h03, 1'b1, 4'd3, "hash_digit2");
        rd(A_D0 + 8'd3, 8'h00, 1'b1, 4'd3, "hash_digit3_empty");
        wr(A_CTL, 8'h03);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "hash_ack");

        // Short tone rejected
        tone(4'd5, 1000, 20);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "short_tone");

        // 5,6 then timeout; tones ignored while complete
        tone(4'd5, 1100, 20);
        tone(4'd6, 1100, 20);
        rd(A_ST, 8'h12, 1'b0, 4'd2, "pre_timeout");
        cyc(TMO + 100);
        rd(A_ST, 8'hD2, 1'b1, 4'd2, "timeout_status");
        rd(A_D0 + 8'd1, 8'h06, 1'b1, 4'd2, "timeout_digit1");
        tone(4'd7, 1100, 20);
        rd(A_ST, 8'hD2, 1'b1, 4'd2, "complete_ignores_tone");
        wr(A_CTL, 8'h03);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "timeout_ack");

        // Nine digits then # -> overflow
        for (int d = 1; d <= 9; d++) begin
            tone(4'(d), 1100, 20);
        end
        tone(4'd12, 1100, 20);
        rd(A_ST, 8'hB8, 1'b1, 4'd8, "overflow_status");
        rd(A_D0 + 8'd7, 8'h08, 1'b1, 4'd8, "overflow_digit7");
        wr(A_CTL, 8'h03);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "overflow_ack_next_cycle");

        // 4,*,7,#
        tone(4'd4, 1100, 20);
        tone(4'd11, 1100, 20);
        tone(4'd7, 1100, 20);
        tone(4'd12, 1100, 20);
        rd(A_ST, 8'h91, 1'b1, 4'd1, "star_status");
        rd(A_D0, 8'h07, 1'b1, 4'd1, "star_digit0");
        rd(A_D0 + 8'd1, 8'h00, 1'b1, 4'd1, "star_digit1_empty");
        wr(A_CTL, 8'h03);

        // Writes outside the window or to read-only offsets do nothing
        wr(8'h20, 8'h00);
        wr(A_ST, 8'hFF);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "ignored_writes");

        // Disable blocks tones
        wr(A_CTL, 8'h00);
        rd(A_ST, 8'h00, 1'b0, 4'd0, "disabled_status");
        tone(4'd1, 1100, 20);
        rd(A_ST, 8'h00, 1'b0, 4'd0, "disabled_tone");
        wr(A_CTL, 8'h02);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "reenabled");

        // Daisy-chain pass-through
        bus.rd_data_in = 8'hA5;
        rd(8'h10, 8'hA5, 1'b0, 4'd0, "passthrough");
        bus.rd_data_in = 8'h00;

        // Reset in mid-QUALIFY with the tone still present afterwards
        dig = 4'd3;
        det = 1'b1;
        cyc(500);
        reset = 1'b0;
        cyc(1);
        rd(A_ST, 8'h00, 1'b0, 4'd0, "reset_mid_tone");
        cyc(2);
        reset = 1'b1;
        cyc(1500);
        det = 1'b0;
        cyc(20);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "tone_after_reset");

        // Reset in COMPLETE abandons the command
        tone(4'd9, 1100, 20);
        tone(4'd12, 1100, 20);
        rd(A_ST, 8'h91, 1'b1, 4'd1, "pre_reset_complete");
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        rd(A_ST, 8'h10, 1'b0, 4'd0, "reset_complete_status");
        rd(A_D0, 8'h00, 1'b0, 4'd0, "reset_complete_digit0");

        cyc(5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the run is a fixed sequence well below this bound.
    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
